mux4_rr_arbiter: RTL
====================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: W, 1, data width of each mux input and of z.
REQ-003 Parameter: MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant while others wait (legal range 1..15).
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: req  input  4  request bit per source; bit i requests input di.
REQ-007 Port: d0, d1, d2, d3  input  W each  source data.
REQ-008 Port: sel  output  2  registered select of the shared 4->1 mux; index of current owner.
REQ-009 Port: gnt  output  4  registered grant, one-hot or zero.
REQ-010 Port: valid  output  1  registered; 1 when gnt is nonzero.
REQ-011 Port: z  output  W  shared mux output.

Function
REQ-012 The FSM SHALL have two states, IDLE and GRANT, plus registers last[1:0] (last owner) and hold_cnt[3:0].
REQ-013 IDLE: if req==0, stay; else go to GRANT at the next edge with owner = first set bit of req searched from (last+1) mod 4 upward, wrapping.
REQ-014 Grant latency SHALL be exactly one cycle: req sampled at edge n gives gnt/sel/valid at edge n+1.
REQ-015 On every new grant: gnt = one-hot(owner), sel = owner, valid = 1, last = owner, hold_cnt = 1.
REQ-016 GRANT, req[owner]==1 and hold_cnt<MAX_HOLD: keep owner, hold_cnt += 1.
REQ-017 GRANT, req[owner]==1, hold_cnt==MAX_HOLD, and another req bit set: rearbitrate per REQ-013, excluding the owner; new owner takes effect at the next edge with no idle cycle.
REQ-018 GRANT, req[owner]==1, hold_cnt==MAX_HOLD, and no other req bit set: keep owner and restart hold_cnt at 1; gnt shows no gap.
REQ-019 GRANT, req[owner]==0 and other req bits set: rearbitrate per REQ-013 at the next edge with no bubble.
REQ-020 GRANT, req[owner]==0 and req==0: go to IDLE; gnt=0, valid=0 at the next edge; sel holds its last value.
REQ-021 The arbiter SHALL NOT take the grant from an owner whose req is high before MAX_HOLD cycles.
REQ-022 z SHALL be combinational: z = d[sel] when valid==1, else all zeros.
REQ-023 gnt SHALL never have more than one bit set, and SHALL never be nonzero when valid==0.
REQ-024 Simultaneous requests SHALL be served in round-robin order; no source may wait more than 3*MAX_HOLD+1 cycles while its req stays high.

Reset
REQ-025 When rst is high, asynchronously: state=IDLE, gnt=0, sel=0, valid=0, z=0, hold_cnt=0, last=3, so req[0] has first priority after reset.
REQ-026 Reset asserted mid-grant SHALL clear outputs immediately, without waiting for a clock edge; arbitration resumes at the first edge after rst falls.
REQ-027 req SHALL be ignored while rst is high.

Verification
REQ-028 rst=1 with req=1111 -> gnt=0000, valid=0, z=0. After rst falls -> first edge gives gnt=0001, sel=0.
REQ-029 MAX_HOLD=4, req=1111 held -> owners 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0 with no zero-gnt cycle.
REQ-030 req=0100 held 10 cycles -> gnt=0100 and valid=1 for all 10 cycles starting 1 cycle after req rises; hold_cnt wraps 4->1.
REQ-031 req=0011, owner 0 drops req0 after 2 cycles -> next edge gnt=0010, sel=1. Then req=0000 -> next edge gnt=0000, valid=0, sel stays 1.
REQ-032 gnt=0010, d1=1, d0=d2=d3=0 -> z=1. d1 toggled -> z follows in the same cycle. After drop to IDLE -> z=0.
REQ-033 rst pulsed asynchronously between edges while gnt=1000 -> gnt=0, valid=0, z=0 before the next clk edge. After release with req=1000 -> gnt=1000 one edge later.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
// Round-robin arbiter for four requesters driving a shared 4->1 mux. A
// requester that keeps its request high owns the mux for up to MAX_HOLD
// consecutive cycles before the grant rotates to the next waiting source.
// Grants appear one cycle after the request is sampled.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   req    request bit per source, bit i requests d<i>
//   d0..d3 source data, W bits each
//   sel    registered index of the current owner (holds while idle)
//   gnt    registered one-hot grant, zero when idle
//   valid  registered, high whenever gnt is nonzero
//   z      combinational mux output, d[sel] when valid else zero
module mux4_rr_arbiter #(
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [1:0]   sel,
  output logic [3:0]   gnt,
  output logic         valid,
  output logic [W-1:0] z
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

  state_t     state_reg;
  logic [1:0] last_reg;
  logic [3:0] hold_cnt_reg;

  // Round-robin search: first set bit of r starting at last+1, wrapping.
  // Result bit 2 flags that any bit was found; bits 1:0 are the index.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [2:0] pick_all;
  logic [2:0] pick_oth;
  logic       new_grant;
  logic [1:0] new_owner;

  // While in GRANT, gnt is one-hot of the owner, so masking with ~gnt
  // drops the owner from the candidate set.
  assign pick_all = rr_pick(req, last_reg);
  assign pick_oth = rr_pick(req & ~gnt, last_reg);

  // Arbitration decision for the coming edge.
  always_comb begin
    new_grant = 1'b0;
    new_owner = pick_all[1:0];
    if (state_reg == IDLE) begin
      new_grant = pick_all[2];
    end else if (req[sel]) begin
      // Owner still requesting: only give up the mux once its hold budget
      // is spent and somebody else is actually waiting.
      if (hold_cnt_reg >= MAX_CNT && pick_oth[2]) begin
        new_grant = 1'b1;
        new_owner = pick_oth[1:0];
      end
    end else begin
      new_grant = pick_all[2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt          <= 4'b0000;
      sel          <= 2'd0;
      valid        <= 1'b0;
      hold_cnt_reg <= 4'd0;
      last_reg     <= 2'd3;   // req[0] gets first priority after reset
    end else if (new_grant) begin
      state_reg    <= GRANT;
      gnt          <= 4'b0001 << new_owner;
      sel          <= new_owner;
      valid        <= 1'b1;
      last_reg     <= new_owner;
      hold_cnt_reg <= 4'd1;
    end else if (state_reg == GRANT) begin
      if (req[sel]) begin
        // Sole requester at its limit keeps the grant with a fresh budget.
        hold_cnt_reg <= (hold_cnt_reg >= MAX_CNT) ? 4'd1 : hold_cnt_reg + 4'd1;
      end else begin
        state_reg    <= IDLE;
        gnt          <= 4'b0000;
        valid        <= 1'b0;
        hold_cnt_reg <= 4'd0;
      end
    end
  end

  always_comb begin
    z = '0;
    if (valid) begin
      case (sel)
        2'd0:    z = d0;
        2'd1:    z = d1;
        2'd2:    z = d2;
        default: z = d3;
      endcase
    end
  end

endmodule
